// File: rtl/result_writeback.sv
// result_writeback: adds bias to a raw DSP accumulator, applies leaky ReLU, saturates
// to 18-bit Q(FRAC_BITS) and queues the write in a show-ahead FIFO towards feature-map memory.
module result_writeback #(
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               result_ready,
    input  logic signed [47:0] result_data,
    input  logic signed [17:0] filter_bias,
    input  logic [7:0]         center_x_input,
    input  logic [7:0]         center_y_input,
    input  logic               center_write_enable,
    input  logic [7:0]         out_width,
    output logic               mem_write_en,
    output logic [15:0]        mem_addr,
    output logic signed [17:0] mem_data,
    input  logic               mem_ready,
    output logic               overflow,
    output logic               idle
);
    localparam int unsigned ACC_W  = 48;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 18;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((longint'(1) <<< (DATA_W - 1)) - longint'(1));
    localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - SUM_W'(1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    s1_valid_q, s1_valid_d;
    logic signed [SUM_W-1:0] s1_sum_q, s1_sum_d;
    logic [ADDR_W-1:0]       s1_addr_q, s1_addr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    entry_t                  head_q, head_d;
    logic                    mem_write_en_q, mem_write_en_d;
    logic                    overflow_q, overflow_d;
    logic                    idle_q, idle_d;
    entry_t                  fifo_q [FIFO_DEPTH];

    logic signed [SUM_W-1:0] act_full;
    logic [DATA_W-1:0]       act_sat;
    entry_t                  push_entry;
    logic                    push, pop, full, accept;
    logic [CNT_W-1:0]        remain;

    // Centre address latch and stage 1 (bias add, address capture)
    always_comb begin
        addr_d     = addr_q;
        s1_valid_d = result_ready;
        s1_sum_d   = s1_sum_q;
        s1_addr_d  = s1_addr_q;
        if (center_write_enable) begin
            addr_d = ADDR_W'(ADDR_W'(center_y_input) * ADDR_W'(out_width)) + ADDR_W'(center_x_input);
        end
        if (result_ready) begin
            s1_sum_d  = SUM_W'(result_data) + (SUM_W'(filter_bias) <<< FRAC_BITS);
            s1_addr_d = addr_q;
        end
    end

    // Stage 2: drop fraction, leak negatives, saturate
    always_comb begin
        act_full = s1_sum_q >>> FRAC_BITS;
        if (act_full[SUM_W-1]) begin
            act_full = act_full >>> LEAK_SHIFT;
        end
        if (act_full > SAT_MAX) begin
            act_sat = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (act_full < SAT_MIN) begin
            act_sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            act_sat = DATA_W'(act_full);
        end
        push_entry = '{addr: s1_addr_q, data: act_sat};
    end

    // FIFO control; head register is preloaded so outputs hold when the FIFO drains
    always_comb begin
        push           = s1_valid_q;
        pop            = mem_write_en_q & mem_ready;
        full           = (count_q == CNT_W'(FIFO_DEPTH));
        accept         = push & (~full | pop);
        remain         = count_q - CNT_W'(pop);
        count_d        = remain + CNT_W'(accept);
        rd_ptr_d       = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d       = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        head_d         = head_q;
        if (remain != '0) begin
            head_d = fifo_q[rd_ptr_d];
        end else if (accept) begin
            head_d = push_entry;
        end
        mem_write_en_d = (count_d != '0);
        overflow_d     = overflow_q | (push & full & ~pop);
        idle_d         = ~s1_valid_d & (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q         <= '0;
            s1_valid_q     <= 1'b0;
            s1_sum_q       <= '0;
            s1_addr_q      <= '0;
            count_q        <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            head_q         <= '0;
            mem_write_en_q <= 1'b0;
            overflow_q     <= 1'b0;
            idle_q         <= 1'b1;
        end else begin
            addr_q         <= addr_d;
            s1_valid_q     <= s1_valid_d;
            s1_sum_q       <= s1_sum_d;
            s1_addr_q      <= s1_addr_d;
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            head_q         <= head_d;
            mem_write_en_q <= mem_write_en_d;
            overflow_q     <= overflow_d;
            idle_q         <= idle_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count/pointers
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    assign mem_write_en = mem_write_en_q;
    assign mem_addr     = head_q.addr;
    assign mem_data     = head_q.data;
    assign overflow     = overflow_q;
    assign idle         = idle_q;
endmodule

// File: tb/tb_result_writeback.sv
// Bench for result_writeback: directed scenarios plus a randomized run against
// an arithmetic reference model and an in-order write scoreboard.
module tb_result_writeback;
    localparam int FRAC  = 8;
    localparam int LEAK  = 3;
    localparam int DEPTH = 4;

    logic               clk;
    logic               rst;
    logic               result_ready;
    logic signed [47:0] result_data;
    logic signed [17:0] filter_bias;
    logic [7:0]         cx;
    logic [7:0]         cy;
    logic               center_write_enable;
    logic [7:0]         out_width;
    logic               mem_write_en;
    logic [15:0]        mem_addr;
    logic signed [17:0] mem_data;
    logic               mem_ready;
    logic               overflow;
    logic               idle;

    typedef struct packed {
        logic [15:0] addr;
        logic [17:0] data;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  passed;
    int  total;

    result_writeback #(.FRAC_BITS(FRAC), .LEAK_SHIFT(LEAK), .FIFO_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .result_ready        (result_ready),
        .result_data         (result_data),
        .filter_bias         (filter_bias),
        .center_x_input      (cx),
        .center_y_input      (cy),
        .center_write_enable (center_write_enable),
        .out_width           (out_width),
        .mem_write_en        (mem_write_en),
        .mem_addr            (mem_addr),
        .mem_data            (mem_data),
        .mem_ready           (mem_ready),
        .overflow            (overflow),
        .idle                (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed transfer
    always @(negedge clk) begin
        if (rst && mem_write_en && mem_ready) obs_q.push_back({mem_addr, 18'(mem_data)});
    end

    // Reference: value = floor((P + bias*2^F) / 2^F); negatives divided by 2^L (floor); clamp to 18 bits
    function automatic logic [17:0] act_model(input longint p, input longint b);
        longint v;
        v = (p + b * (longint'(1) << FRAC)) >>> FRAC;
        if (v < 0) v = v >>> LEAK;
        if (v > 131071) v = 131071;
        if (v < -131072) v = -131072;
        return 18'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint p, input longint b);
        result_data  = 48'(p);
        filter_bias  = 18'(b);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; result_ready = 1'b0; result_data = '0; filter_bias = '0;
        cx = '0; cy = '0; center_write_enable = 1'b0; out_width = 8'd32; mem_ready = 1'b0;
        #12;
        total++; if (mem_write_en !== 1'b0) $display("FAIL rst_wen: got %b expected 0", mem_write_en); else passed++;
        total++; if (mem_addr !== 16'd0) $display("FAIL rst_addr: got %0d expected 0", mem_addr); else passed++;
        total++; if (mem_data !== 18'sd0) $display("FAIL rst_data: got %0h expected 0", mem_data); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b expected 0", overflow); else passed++;
        total++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b expected 1", idle); else passed++;
        rst = 1'b1;
        tick();
        mem_ready = 1'b1;
        send(0, 256);
        tick();
        total++; if (mem_addr !== 16'd0) $display("FAIL rst_latch_addr: got %0d expected 0", mem_addr); else passed++;
        total++; if (mem_data !== 18'sh00100) $display("FAIL rst_first_data: got %0h expected 100", mem_data); else passed++;
        tick();
    endtask

    task automatic test_basic();
        out_width = 8'd32; cx = 8'd5; cy = 8'd3; center_write_enable = 1'b1;
        tick();
        center_write_enable = 1'b0;
        mem_ready = 1'b1;
        send(655360, 256);
        total++; if (idle !== 1'b0) $display("FAIL basic_idle_n1: got %b expected 0", idle); else passed++;
        tick();
        total++; if (mem_write_en !== 1'b1) $display("FAIL basic_wen: got %b expected 1", mem_write_en); else passed++;
        total++; if (mem_addr !== 16'd101) $display("FAIL basic_addr: got %0d expected 101", mem_addr); else passed++;
        total++; if (mem_data !== 18'sh00B00) $display("FAIL basic_data: got %0h expected b00", mem_data); else passed++;
        tick();
        total++; if (idle !== 1'b1) $display("FAIL basic_idle_n3: got %b expected 1", idle); else passed++;
        total++; if (mem_write_en !== 1'b0) $display("FAIL basic_wen_n3: got %b expected 0", mem_write_en); else passed++;
        total++; if (mem_data !== 18'sh00B00) $display("FAIL basic_hold: got %0h expected b00", mem_data); else passed++;
    endtask

    task automatic test_leaky_sat();
        logic [17:0] exp_c [4];
        exp_c[0] = 18'h3FE00; exp_c[1] = 18'h3FFFF; exp_c[2] = 18'h1FFFF; exp_c[3] = 18'h20000;
        obs_q.delete();
        mem_ready = 1'b1;
        send(-1048576, 0);
        send(-256, 0);
        send(longint'(1) << 40, 131071);
        send(-(longint'(1) << 40), 0);
        for (int i = 0; i < 40 && idle !== 1'b1; i++) tick();
        total++; if (obs_q.size() != 4) $display("FAIL leaky_count: got %0d expected 4", obs_q.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= obs_q.size() || obs_q[i].data !== exp_c[i] || obs_q[i].addr !== 16'd101)
                $display("FAIL leaky_sat_%0d: got %0h expected %0h", i, (i < obs_q.size()) ? obs_q[i] : 34'h0, {16'd101, exp_c[i]});
            else passed++;
        end
    endtask

    task automatic test_same_cycle();
        obs_q.delete();
        mem_ready = 1'b1;
        cx = 8'd7; cy = 8'd0; center_write_enable = 1'b1;
        result_data = 48'(3 * 65536); filter_bias = '0; result_ready = 1'b1;
        tick();
        center_write_enable = 1'b0;
        send(9 * 65536, 0);
        for (int i = 0; i < 40 && idle !== 1'b1; i++) tick();
        total++; if (obs_q.size() != 2) $display("FAIL same_count: got %0d expected 2", obs_q.size()); else passed++;
        total++; if (obs_q.size() < 1 || obs_q[0] !== {16'd101, 18'h00300}) $display("FAIL same_old_addr: got %0h expected %0h", (obs_q.size() > 0) ? obs_q[0] : 34'h0, {16'd101, 18'h00300}); else passed++;
        total++; if (obs_q.size() < 2 || obs_q[1] !== {16'd7, 18'h00900}) $display("FAIL same_new_addr: got %0h expected %0h", (obs_q.size() > 1) ? obs_q[1] : 34'h0, {16'd7, 18'h00900}); else passed++;
        // Fill the FIFO, then a result arrives exactly as the first pop happens
        obs_q.delete();
        mem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send(longint'(k) * 65536, 0);
        tick();
        total++; if (mem_write_en !== 1'b1) $display("FAIL full_wen: got %b expected 1", mem_write_en); else passed++;
        send(5 * 65536, 0);
        mem_ready = 1'b1;
        tick();
        total++; if (overflow !== 1'b0) $display("FAIL full_pushpop_ovf: got %b expected 0", overflow); else passed++;
        for (int i = 0; i < 40 && idle !== 1'b1; i++) tick();
        total++; if (obs_q.size() != 5) $display("FAIL full_count: got %0d expected 5", obs_q.size()); else passed++;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (k >= obs_q.size() || obs_q[k] !== {16'd7, 18'((k + 1) * 256)})
                $display("FAIL full_order_%0d: got %0h expected %0h", k, (k < obs_q.size()) ? obs_q[k] : 34'h0, {16'd7, 18'((k + 1) * 256)});
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [15:0]        maddr;
        logic [15:0]        naddr;
        logic [7:0]         w;
        logic signed [47:0] r48;
        logic signed [17:0] r18;
        longint             p;
        longint             b;
        bit                 do_res;
        bit                 do_cw;
        obs_q.delete(); exp_q.delete();
        w = 8'($urandom_range(1, 255)); out_width = w;
        cx = 8'($urandom); cy = 8'($urandom); center_write_enable = 1'b1;
        tick();
        center_write_enable = 1'b0;
        maddr = 16'(int'(cy) * int'(w) + int'(cx));
        for (int c = 0; c < 300; c++) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            do_cw     = ($urandom_range(0, 7) == 0);
            do_res    = ($urandom_range(0, 1) == 1) && ((exp_q.size() - obs_q.size()) < DEPTH);
            naddr     = maddr;
            if (do_res) begin
                r48 = 48'({$urandom, $urandom});
                case ($urandom_range(0, 3))
                    0: r48 = r48 >>> 28;
                    1: r48 = r48 >>> 22;
                    2: r48 = r48 >>> 12;
                    default: ;
                endcase
                r18 = 18'($urandom);
                p = r48; b = r18;
                result_data = r48; filter_bias = r18; result_ready = 1'b1;
                exp_q.push_back({maddr, act_model(p, b)});
            end else begin
                result_ready = 1'b0;
            end
            if (do_cw) begin
                cx = 8'($urandom); cy = 8'($urandom); center_write_enable = 1'b1;
                naddr = 16'(int'(cy) * int'(w) + int'(cx));
            end else begin
                center_write_enable = 1'b0;
            end
            tick();
            maddr = naddr;
        end
        result_ready = 1'b0; center_write_enable = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 60 && idle !== 1'b1; i++) tick();
        total++; if (idle !== 1'b1) $display("FAIL rand_drain: idle got %b expected 1", idle); else passed++;
        total++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rand_ovf: got %b expected 0", overflow); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                $display("FAIL rand_write_%0d: got %0h expected %0h", i, (i < obs_q.size()) ? obs_q[i] : 34'h0, exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_overflow();
        obs_q.delete();
        mem_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send(longint'(k) * 65536, 0);
        tick();
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", overflow); else passed++;
        mem_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            total++; if (mem_write_en !== 1'b1) $display("FAIL ovf_wen_%0d: got %b expected 1", k, mem_write_en); else passed++;
            total++; if (mem_data !== 18'(k * 256)) $display("FAIL ovf_data_%0d: got %0h expected %0h", k, mem_data, 18'(k * 256)); else passed++;
            tick();
        end
        total++; if (mem_write_en !== 1'b0) $display("FAIL ovf_empty: got %b expected 0", mem_write_en); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else passed++;
        total++; if (obs_q.size() != 4) $display("FAIL ovf_count: got %0d expected 4", obs_q.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        obs_q.delete();
        mem_ready = 1'b0;
        for (int k = 1; k <= 3; k++) send(longint'(k) * 65536 + 4096, 0);
        tick();
        total++; if (mem_write_en !== 1'b1) $display("FAIL mid_pre_wen: got %b expected 1", mem_write_en); else passed++;
        #3;
        rst = 1'b0;
        #1;
        total++; if (mem_write_en !== 1'b0) $display("FAIL mid_wen: got %b expected 0", mem_write_en); else passed++;
        total++; if (mem_addr !== 16'd0) $display("FAIL mid_addr: got %0d expected 0", mem_addr); else passed++;
        total++; if (mem_data !== 18'sd0) $display("FAIL mid_data: got %0h expected 0", mem_data); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL mid_ovf: got %b expected 0", overflow); else passed++;
        total++; if (idle !== 1'b1) $display("FAIL mid_idle: got %b expected 1", idle); else passed++;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        mem_ready = 1'b1;
        repeat (10) tick();
        total++; if (obs_q.size() != 0) $display("FAIL mid_no_write: got %0d writes expected 0", obs_q.size()); else passed++;
        total++; if (mem_write_en !== 1'b0) $display("FAIL mid_post_wen: got %b expected 0", mem_write_en); else passed++;
        total++; if (idle !== 1'b1) $display("FAIL mid_post_idle: got %b expected 1", idle); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_basic();
        test_leaky_sat();
        test_same_cycle();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
